// File: rtl/ucsbece154b_mem_sched.sv
// ucsbece154b_mem_sched
// Shared-memory burst scheduler. The I-side and D-side miss paths share one
// external memory read port. Whole bursts are arbitrated round-robin, and one
// aligned burst request is issued per grant. The returned beats are then routed
// back to the side that owns the burst.
module ucsbece154b_mem_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ireq_valid_i,
  input  logic [ADDR_WIDTH-1:0] ireq_addr_i,
  output logic                  ireq_ready_o,
  input  logic                  dreq_valid_i,
  input  logic [ADDR_WIDTH-1:0] dreq_addr_i,
  output logic                  dreq_ready_o,
  output logic                  mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_req_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic [DATA_WIDTH-1:0] iresp_data_o,
  output logic                  iresp_valid_o,
  output logic                  iresp_last_o,
  output logic [DATA_WIDTH-1:0] dresp_data_o,
  output logic                  dresp_valid_o,
  output logic                  dresp_last_o,
  output logic                  busy_o
);

  // A burst covers BURST_LEN beats of DATA_WIDTH/8 bytes each, so the address
  // is aligned to that many bytes.
  localparam int OFFS_BITS = $clog2(BURST_LEN * DATA_WIDTH / 8);
  localparam int CNT_W     = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFFS_BITS) - ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_t;

  state_t                state_q, state_d;
  side_t                 owner_q, owner_d;
  side_t                 lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  grantI, grantD;

  // The stored address is already aligned, so it drives the memory port directly.
  assign mem_req_addr_o = addr_q;
  assign busy_o         = (state_q != IDLE);

  // State registers. An asynchronous reset drops any in-flight burst at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= SIDE_I;
      lastGrant_q <= SIDE_I;
      cnt_q       <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
    end
  end

  // Round-robin pick. A lone requester always wins; on a tie the side not
  // granted last wins. Nothing is granted while reset is held.
  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (!rst_i) begin
      grantI = ireq_valid_i && (!dreq_valid_i || lastGrant_q == SIDE_D);
      grantD = dreq_valid_i && (!ireq_valid_i || lastGrant_q == SIDE_I);
    end
  end

  // Next-state logic plus the combinational handshake and response routing.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    lastGrant_d     = lastGrant_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    ireq_ready_o    = 1'b0;
    dreq_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    iresp_data_o    = '0;
    iresp_valid_o   = 1'b0;
    iresp_last_o    = 1'b0;
    dresp_data_o    = '0;
    dresp_valid_o   = 1'b0;
    dresp_last_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grantI) begin
          ireq_ready_o = 1'b1;
          owner_d      = SIDE_I;
          lastGrant_d  = SIDE_I;
          addr_d       = ireq_addr_i & ALIGN_MASK;
          state_d      = REQ;
        end else if (grantD) begin
          dreq_ready_o = 1'b1;
          owner_d      = SIDE_D;
          lastGrant_d  = SIDE_D;
          addr_d       = dreq_addr_i & ALIGN_MASK;
          state_d      = REQ;
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (mem_rvalid_i) begin
          if (owner_q == SIDE_I) begin
            iresp_data_o  = mem_rdata_i;
            iresp_valid_o = 1'b1;
            iresp_last_o  = (cnt_q == LAST_BEAT);
          end else begin
            dresp_data_o  = mem_rdata_i;
            dresp_valid_o = 1'b1;
            dresp_last_o  = (cnt_q == LAST_BEAT);
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ucsbece154b_mem_sched.sv
// Testbench for ucsbece154b_mem_sched. A request-level model (pending
// requests, last grant side, burst alignment by modulo) predicts grants,
// addresses and beat routing under directed and randomized traffic.
module tb_ucsbece154b_mem_sched;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BL    = 4;
  localparam int BYTES = BL * DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ireq_valid = 1'b0;
  logic [AW-1:0] ireq_addr = '0;
  logic          ireq_ready;
  logic          dreq_valid = 1'b0;
  logic [AW-1:0] dreq_addr = '0;
  logic          dreq_ready;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] iresp_data;
  logic          iresp_valid;
  logic          iresp_last;
  logic [DW-1:0] dresp_data;
  logic          dresp_valid;
  logic          dresp_last;
  logic          busy;

  int total = 0;
  int bad   = 0;
  // Model: side granted most recently (0 = I, 1 = D)
  bit mdlLast = 1'b0;

  ucsbece154b_mem_sched #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ireq_valid_i   (ireq_valid),
    .ireq_addr_i    (ireq_addr),
    .ireq_ready_o   (ireq_ready),
    .dreq_valid_i   (dreq_valid),
    .dreq_addr_i    (dreq_addr),
    .dreq_ready_o   (dreq_ready),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_addr_o (mem_req_addr),
    .mem_req_ready_i(mem_req_ready),
    .mem_rdata_i    (mem_rdata),
    .mem_rvalid_i   (mem_rvalid),
    .iresp_data_o   (iresp_data),
    .iresp_valid_o  (iresp_valid),
    .iresp_last_o   (iresp_last),
    .dresp_data_o   (dresp_data),
    .dresp_valid_o  (dresp_valid),
    .dresp_last_o   (dresp_last),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a - (a % BYTES);
  endfunction

  // Presents requests while the scheduler is idle and checks the grant against the model
  task automatic do_grant(input bit iv, input logic [AW-1:0] ia, input bit dv,
                          input logic [AW-1:0] da, output bit obsD,
                          output bit expD, output logic [AW-1:0] expAddr);
    ireq_valid = iv; ireq_addr = ia;
    dreq_valid = dv; dreq_addr = da;
    expD    = (iv && dv) ? !mdlLast : dv;
    expAddr = expD ? align(da) : align(ia);
    @(negedge clk);
    obsD = dreq_ready;
    total++;
    if ({ireq_ready, dreq_ready, mem_req_valid, busy} !== {!expD, expD, 1'b0, 1'b0})
      $display("[TB] FAIL grant: got ir/dr/mv/busy=%b%b%b%b want %b%b00",
               ireq_ready, dreq_ready, mem_req_valid, busy, !expD, expD);
    if ({ireq_ready, dreq_ready, mem_req_valid, busy} !== {!expD, expD, 1'b0, 1'b0}) bad++;
    mdlLast = expD;
    @(posedge clk); #1;
    if (expD) dreq_valid = 1'b0; else ireq_valid = 1'b0;
  endtask

  // Plays memory for one burst, starting in the cycle after the grant
  task automatic serve_burst(input bit expD, input logic [AW-1:0] expAddr,
                             input int reqDelay, input logic [15:0] pat,
                             input int patLen, input bit useBase,
                             input logic [DW-1:0] dataBase);
    int beats;
    int cyc;
    bit rv;
    bit lastExp;
    logic [DW-1:0] data;
    logic [DW-1:0] ownData;
    for (int c = 0; c <= reqDelay; c++) begin
      mem_req_ready = (c == reqDelay);
      mem_rvalid    = 1'b1;
      mem_rdata     = 32'h0000_DEAD;
      @(negedge clk);
      total++;
      if ({mem_req_valid, mem_req_addr, ireq_ready, dreq_ready, iresp_valid, dresp_valid, busy}
          !== {1'b1, expAddr, 4'b0000, 1'b1}) begin
        bad++;
        $display("[TB] FAIL req_phase: got mv=%b addr=%h ir=%b dr=%b iv=%b dv=%b busy=%b want mv=1 addr=%h others 0 busy=1",
                 mem_req_valid, mem_req_addr, ireq_ready, dreq_ready, iresp_valid, dresp_valid,
                 busy, expAddr);
      end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < BL && cyc < 64) begin
      rv   = (cyc < patLen) ? pat[cyc] : ($urandom_range(99) >= 30);
      data = useBase ? dataBase + DW'(beats) : DW'($urandom);
      mem_rvalid = rv;
      mem_rdata  = data;
      @(negedge clk);
      lastExp = rv && (beats == BL - 1);
      total++;
      if ({iresp_valid, iresp_last, dresp_valid, dresp_last, mem_req_valid, busy} !==
          {rv && !expD, lastExp && !expD, rv && expD, lastExp && expD, 1'b0, 1'b1}) begin
        bad++;
        $display("[TB] FAIL beat_ctrl: got iv/il/dv/dl/mv/busy=%b%b%b%b%b%b want %b%b%b%b01",
                 iresp_valid, iresp_last, dresp_valid, dresp_last, mem_req_valid, busy,
                 rv && !expD, lastExp && !expD, rv && expD, lastExp && expD);
      end
      if (rv) begin
        ownData = expD ? dresp_data : iresp_data;
        total++;
        if (ownData !== data) begin
          bad++;
          $display("[TB] FAIL beat_data: got %h want %h", ownData, data);
        end
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_rvalid = 1'b0;
    if (beats != BL) begin
      total++;
      bad++;
      $display("[TB] FAIL burst_timeout: got %0d beats want %0d", beats, BL);
    end
  endtask

  // Reset puts every output at zero and blocks grants while it is held
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++;
    if ({ireq_ready, dreq_ready, mem_req_valid, mem_req_addr, iresp_data, iresp_valid,
         iresp_last, dresp_data, dresp_valid, dresp_last, busy} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got busy=%b mv=%b addr=%h want all zero",
               busy, mem_req_valid, mem_req_addr);
    end
    ireq_valid = 1'b1;
    dreq_valid = 1'b1;
    #1;
    total++;
    if ({ireq_ready, dreq_ready} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b%b want 00", ireq_ready, dreq_ready);
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mdlLast = 1'b0;
  endtask

  // A lone I request at 0x1234 with memory ready at once and beats A0..A3
  task automatic test_single_i();
    bit obsD, expD;
    logic [AW-1:0] expAddr;
    do_grant(1'b1, 32'h0000_1234, 1'b0, '0, obsD, expD, expAddr);
    serve_burst(1'b0, 32'h0000_1230, 0, 16'h000F, 4, 1'b1, 32'h0000_00A0);
  endtask

  // Both sides hold requests continuously, so grants alternate D, I, D
  task automatic test_tie();
    bit obsD, expD;
    logic [AW-1:0] expAddr;
    bit wantD [3] = '{1'b1, 1'b0, 1'b1};
    logic [AW-1:0] ia, da;
    ia = $urandom;
    da = $urandom;
    for (int b = 0; b < 3; b++) begin
      do_grant(1'b1, ia, 1'b1, da, obsD, expD, expAddr);
      total++;
      if (obsD !== wantD[b]) begin
        bad++;
        $display("[TB] FAIL tie_order%0d: got dreq_ready=%b want %b", b, obsD, wantD[b]);
      end
      if (expD) da = $urandom; else ia = $urandom;
      ireq_valid = 1'b1; ireq_addr = ia;
      dreq_valid = 1'b1; dreq_addr = da;
      serve_burst(expD, expAddr, $urandom_range(2), '0, 0, 1'b0, '0);
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
  endtask

  // A five-cycle memory stall while a D request waits; the D request is served afterwards
  task automatic test_stall();
    bit obsD, expD;
    logic [AW-1:0] expAddr;
    logic [AW-1:0] da;
    da = $urandom;
    do_grant(1'b1, $urandom, 1'b0, '0, obsD, expD, expAddr);
    dreq_valid = 1'b1;
    dreq_addr  = da;
    serve_burst(expD, expAddr, 5, '0, 0, 1'b0, '0);
    do_grant(1'b0, '0, 1'b1, da, obsD, expD, expAddr);
    serve_burst(expD, expAddr, 1, '0, 0, 1'b0, '0);
  endtask

  // Beats arrive with the valid pattern 1,0,0,1,1,0,1; idle right after the fourth beat
  task automatic test_bubbles();
    bit obsD, expD;
    logic [AW-1:0] expAddr;
    do_grant(1'b0, '0, 1'b1, $urandom, obsD, expD, expAddr);
    serve_burst(expD, expAddr, 0, 16'h0059, 7, 1'b0, '0);
    @(negedge clk);
    total++;
    if ({busy, mem_req_valid} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL idle_after_bubbles: got busy=%b mv=%b want 00", busy, mem_req_valid);
    end
    @(posedge clk); #1;
  endtask

  // A stray beat in IDLE must not reach either side (REQ strays are injected in serve_burst)
  task automatic test_stray();
    bit obsD, expD;
    logic [AW-1:0] expAddr;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_DEAD;
    @(negedge clk);
    total++;
    if ({iresp_valid, dresp_valid, busy, mem_req_valid} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL stray_idle: got iv=%b dv=%b busy=%b mv=%b want 0000",
               iresp_valid, dresp_valid, busy, mem_req_valid);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    do_grant(1'b1, $urandom, 1'b0, '0, obsD, expD, expAddr);
    serve_burst(expD, expAddr, 3, '0, 0, 1'b0, '0);
  endtask

  // Reset after the second beat of a D burst, then a fresh I request completes
  task automatic test_midreset();
    bit obsD, expD;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] data;
    do_grant(1'b0, '0, 1'b1, $urandom, obsD, expD, expAddr);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      data = $urandom;
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      @(negedge clk);
      total++;
      if ({dresp_valid, dresp_data, iresp_valid} !== {1'b1, data, 1'b0}) begin
        bad++;
        $display("[TB] FAIL midreset_beat%0d: got dv=%b data=%h iv=%b want dv=1 data=%h iv=0",
                 k, dresp_valid, dresp_data, iresp_valid, data);
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ireq_ready, dreq_ready, mem_req_valid, mem_req_addr, iresp_data, iresp_valid,
         iresp_last, dresp_data, dresp_valid, dresp_last, busy} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got busy=%b dv=%b data=%h addr=%h want all zero",
               busy, dresp_valid, dresp_data, mem_req_addr);
    end
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdlLast = 1'b0;
    do_grant(1'b1, $urandom, 1'b0, '0, obsD, expD, expAddr);
    total++;
    if (obsD !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_regrant: got dreq_ready=%b want 0", obsD);
    end
    serve_burst(expD, expAddr, 0, '0, 0, 1'b0, '0);
  endtask

  // Random arrivals; a request that loses arbitration stays pending until granted
  task automatic test_random();
    bit obsD, expD;
    logic [AW-1:0] expAddr;
    bit pendI, pendD;
    logic [AW-1:0] ia, da;
    pendI = 1'b0;
    pendD = 1'b0;
    ia = '0;
    da = '0;
    for (int n = 0; n < 24; n++) begin
      if (!pendI && $urandom_range(1) == 1) begin pendI = 1'b1; ia = $urandom; end
      if (!pendD && $urandom_range(1) == 1) begin pendD = 1'b1; da = $urandom; end
      if (!pendI && !pendD) begin pendI = 1'b1; ia = $urandom; end
      do_grant(pendI, ia, pendD, da, obsD, expD, expAddr);
      if (expD) pendD = 1'b0; else pendI = 1'b0;
      serve_burst(expD, expAddr, $urandom_range(3), '0, 0, 1'b0, '0);
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_tie();
    test_stall();
    test_bubbles();
    test_stray();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
